decoder_scan: RTL and testbench

- Registered, parametrised N-to-2^N decoder with a valid/ready input handshake.
- Three static decode modes: one-hot, thermometer and active-low one-hot.
- One auto-scan mode: a walking-one sweeps the outputs from a start index with a programmable dwell per index.
- Next-generation successor of the combinational decoder; used for address/row select and sequenced enable strobes in the same datapaths.

---
 rtl/decoder_scan.sv | 141 ++++++++++++++
 tb/tb_decoder_scan.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/decoder_scan.sv
// Registered N-to-2^N decoder with one-hot / thermometer / active-low modes
// and a walking-one auto-scan with programmable per-index dwell.

module decoder_scan_lane #(
  parameter int N = 4,
  parameter int K = 0
) (
  input  logic [1:0]   mode,
  input  logic [N-1:0] sel,
  output logic         bit_o
);
  localparam logic [N-1:0] KI = N'(K);

  always_comb begin
    bit_o = (sel == KI);
    case (mode)
      2'b01:   bit_o = (KI <= sel);
      2'b10:   bit_o = (sel != KI);
      default: bit_o = (sel == KI);
    endcase
  end
endmodule

module decoder_scan #(
  parameter int N       = 4,
  parameter int DWELL_W = 4,
  parameter int OP_SIZE = 1 << N
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         mode,
  input  logic [N-1:0]       a,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OP_SIZE-1:0] op,
  output logic [N-1:0]       idx,
  output logic               out_valid,
  output logic               scan_busy,
  output logic               scan_done
);
  localparam logic [N-1:0] LAST = '1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t               state_q, state_d;
  logic [OP_SIZE-1:0]   op_q, op_d;
  logic [N-1:0]         idx_q, idx_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0]   dw_q, dw_d;
  logic                 ov_q, ov_d;
  logic                 sd_q, sd_d;

  logic [1:0]           dec_mode;
  logic [N-1:0]         dec_sel;
  logic [OP_SIZE-1:0]   dec;

  // One decode lane per output bit; shared by static decode and scan advance.
  for (genvar k = 0; k < OP_SIZE; k++) begin : g_lane
    decoder_scan_lane #(.N(N), .K(k)) u_lane (
      .mode  (dec_mode),
      .sel   (dec_sel),
      .bit_o (dec[k])
    );
  end

  assign scan_busy = (state_q == SCAN);
  assign in_ready  = en && !scan_busy;
  assign out_valid = ov_q && en;
  assign scan_done = sd_q && en;
  assign op        = op_q;
  assign idx       = idx_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    dw_d     = dw_q;
    ov_d     = 1'b0;
    sd_d     = 1'b0;
    dec_sel  = a;
    dec_mode = mode;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_d  = dec;
            idx_d = a;
            ov_d  = 1'b1;
            if (mode == 2'b11) begin
              state_d = SCAN;
              cnt_d   = dwell;
              dw_d    = dwell;
            end
          end
        end
        SCAN: begin
          dec_sel  = idx_q + 1'b1;
          dec_mode = 2'b00;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (idx_q != LAST) begin
            idx_d = idx_q + 1'b1;
            op_d  = dec;
            ov_d  = 1'b1;
            cnt_d = dw_q;
          end else begin
            // No wrap: the last index ends the scan instead of returning to 0.
            op_d    = '0;
            idx_d   = '0;
            sd_d    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      dw_q    <= '0;
      ov_q    <= 1'b0;
      sd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dw_q    <= dw_d;
      ov_q    <= ov_d;
      sd_q    <= sd_d;
    end
  end
endmodule

// File: tb/tb_decoder_scan.sv
// Randomized + directed bench for decoder_scan against a cycle-level reference model.

module tb_decoder_scan;
  localparam int N = 4, DW = 4, OPS = 16;

  logic           clk = 1'b0;
  logic           rst_n, en, in_valid;
  logic [1:0]     mode;
  logic [N-1:0]   a;
  logic [DW-1:0]  dwell;
  logic           in_ready, out_valid, scan_busy, scan_done;
  logic [OPS-1:0] op;
  logic [N-1:0]   idx;

  decoder_scan #(.N(N), .DWELL_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .a(a), .dwell(dwell), .op(op), .idx(idx),
    .out_valid(out_valid), .scan_busy(scan_busy), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0, busy_seen = 0;

  // Reference model: current shown value plus "cycles left at this index".
  logic [OPS-1:0] m_op;
  int             m_idx, m_left, m_dw;
  bit             m_busy, m_pulse, m_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      if (errs <= 40) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_op = '0; m_idx = 0; m_left = 0; m_dw = 0;
    m_busy = 0; m_pulse = 0; m_done = 0;
  endtask

  function automatic logic [OPS-1:0] ref_decode(input int md, input int sel);
    logic [OPS-1:0] r;
    r = '0;
    for (int k = 0; k < OPS; k++) begin
      case (md)
        1:       r[k] = (k <= sel);
        2:       r[k] = (k != sel);
        default: r[k] = (k == sel);
      endcase
    end
    return r;
  endfunction

  task automatic model_edge();
    m_pulse = 0; m_done = 0;
    if (!en) return;
    if (m_busy) begin
      if (m_left > 1) m_left--;
      else if (m_idx < OPS - 1) begin
        m_idx++; m_op = ref_decode(0, m_idx); m_left = m_dw + 1; m_pulse = 1;
      end else begin
        m_op = '0; m_idx = 0; m_busy = 0; m_done = 1;
      end
    end else if (in_valid) begin
      m_idx = int'(a); m_pulse = 1;
      if (mode == 2'b11) begin
        m_op = ref_decode(0, m_idx); m_busy = 1; m_dw = int'(dwell); m_left = m_dw + 1;
      end else m_op = ref_decode(int'(mode), m_idx);
    end
  endtask

  task automatic check_all();
    chk("op", op, m_op);
    chk("idx", idx, m_idx);
    chk("out_valid", out_valid, m_pulse && en);
    chk("scan_done", scan_done, m_done && en);
    chk("scan_busy", scan_busy, m_busy);
    chk("in_ready", in_ready, en && !m_busy);
    if (scan_busy) busy_seen++;
  endtask

  // Drive at negedge, check combinational masking, advance one edge, check registers.
  task automatic cyc(input bit e, input bit v, input int md, input int aa, input int dw);
    en = e; in_valid = v; mode = 2'(md); a = N'(aa); dwell = DW'(dw);
    #1;
    chk("rdy_now", in_ready, e && !m_busy);
    chk("ov_mask", out_valid, m_pulse && e);
    chk("sd_mask", scan_done, m_done && e);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic run_to_done(input int limit);
    int i;
    for (i = 0; i < limit && m_busy; i++) cyc(1, 0, 0, 0, 0);
    if (m_busy) chk("scan_timeout", 32'd1, 32'd0);
  endtask

  logic [OPS-1:0] seq [6];

  initial begin
    seq = '{16'h2000, 16'h2000, 16'h4000, 16'h4000, 16'h8000, 16'h8000};
    rst_n = 0; en = 0; in_valid = 0; mode = 0; a = 0; dwell = 0;
    model_reset();
    #2;
    chk("rst_op", op, 0); chk("rst_idx", idx, 0); chk("rst_ov", out_valid, 0);
    chk("rst_busy", scan_busy, 0); chk("rst_done", scan_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Static modes
    cyc(1, 1, 0, 5, 0);  chk("oh5_op", op, 16'h0020); chk("oh5_ov", out_valid, 1);
    cyc(1, 0, 0, 0, 0);  chk("oh5_hold", op, 16'h0020); chk("oh5_ov_off", out_valid, 0);
    cyc(1, 1, 1, 0, 0);  chk("th0", op, 16'h0001);
    cyc(1, 1, 1, 7, 0);  chk("th7", op, 16'h00FF);
    cyc(1, 1, 1, 15, 0); chk("th15", op, 16'hFFFF);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 2, 3, 0);  chk("al3", op, 16'hFFF7); chk("al3_ov", out_valid, 1);
    cyc(1, 0, 0, 0, 0);

    // Scan a=13 dwell=1; in_valid held with another mode must be ignored
    busy_seen = 0;
    cyc(1, 1, 3, 13, 1); chk("sc13_0", op, seq[0]);
    for (int i = 1; i < 6; i++) begin
      cyc(1, 1, 0, 2, 0); chk("sc13_seq", op, seq[i]); chk("sc13_rdy", in_ready, 0);
    end
    cyc(1, 0, 0, 0, 0);
    chk("sc13_end_op", op, 0); chk("sc13_done", scan_done, 1); chk("sc13_rdy1", in_ready, 1);
    chk("sc13_len", busy_seen, 6);

    // Single-step scan then back-to-back static request
    cyc(1, 1, 3, 15, 0); chk("sc15_op", op, 16'h8000);
    cyc(1, 1, 0, 1, 0);  chk("sc15_done", scan_done, 1); chk("sc15_ov", out_valid, 0);
    cyc(1, 1, 0, 1, 0);  chk("b2b_op", op, 16'h0002);
    cyc(1, 0, 0, 0, 0);

    // Scan a=0 dwell=2 with 5-cycle enable stall mid-dwell
    busy_seen = 0;
    cyc(1, 1, 3, 0, 2);
    cyc(1, 0, 0, 0, 0);
    repeat (5) begin
      cyc(0, 1, 0, 0, 0); chk("stall_op", op, 16'h0001);
    end
    run_to_done(200);
    chk("stall_len", busy_seen, 16 * 3 + 5);
    cyc(1, 0, 0, 0, 0);

    // Reset mid-scan at idx 6
    cyc(1, 1, 3, 0, 0);
    for (int i = 0; i < 40 && m_idx != 6; i++) cyc(1, 0, 0, 0, 0);
    chk("pre_rst_idx", idx, 6);
    rst_n = 0;
    #1;
    chk("arst_op", op, 0); chk("arst_busy", scan_busy, 0);
    chk("arst_done", scan_done, 0); chk("arst_idx", idx, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1; en = 1; in_valid = 0;
    #1;
    chk("post_rst_rdy", in_ready, 1);
    @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      int md, dw;
      md = int'($urandom_range(0, 3));
      dw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, md,
          int'($urandom_range(0, OPS - 1)), dw);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
